// File: rtl/start_token_reader.sv
// Consumer endpoint of an HLS start-token FIFO: pops tokens, drives the ap_start/ap_ready handshake, bounds in-flight PE runs.
// Optional stats counters are built when START_TOKEN_READER_STATS_EN is defined.
module start_token_reader #(
  parameter int DATA_WIDTH   = 1,
  parameter int MAX_INFLIGHT = 2,
  parameter int CNT_WIDTH    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tok_empty_n,
  input  logic [DATA_WIDTH-1:0] tok_dout,
  output logic                  tok_read,
  output logic                  ap_start,
  input  logic                  ap_ready,
  input  logic                  ap_done,
  output logic [DATA_WIDTH-1:0] start_data,
  output logic [CNT_WIDTH-1:0]  inflight,
`ifdef START_TOKEN_READER_STATS_EN
  output logic [31:0]           stat_tokens,
  output logic [31:0]           stat_stall,
`endif
  output logic                  err_sticky
);

  typedef enum logic {IDLE, ISSUE} state_t;

  localparam logic [CNT_WIDTH:0] MAX_W = (CNT_WIDTH+1)'(MAX_INFLIGHT);

  state_t                 state_reg, state_next;
  logic [DATA_WIDTH-1:0]  data_reg;
  logic [CNT_WIDTH-1:0]   inflight_reg;
  logic                   err_reg;
  logic                   hold_reg;

  logic                   room;
  logic                   hs;
  logic                   done_eff;
  logic [CNT_WIDTH:0]     post_cnt;
  logic                   free;

  always_comb begin
    state_next = state_reg;
    ap_start   = (state_reg == ISSUE);
    // A full counter only accepts a handshake when a done frees a slot this cycle.
    room       = ({1'b0, inflight_reg} < MAX_W) | ap_done;
    hs         = ap_start & ap_ready & room;
    done_eff   = ap_done & ((inflight_reg != '0) | hs);
    post_cnt   = {1'b0, inflight_reg} + {{CNT_WIDTH{1'b0}}, hs} - {{CNT_WIDTH{1'b0}}, done_eff};
    free       = post_cnt < MAX_W;
    // hold_reg blocks the first pop after reset release.
    tok_read   = tok_empty_n & free & ((state_reg == IDLE) | hs) & ~hold_reg;
    case (state_reg)
      IDLE:    if (tok_read) state_next = ISSUE;
      ISSUE:   if (hs && !tok_read) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      data_reg     <= '0;
      inflight_reg <= '0;
      err_reg      <= 1'b0;
      hold_reg     <= 1'b1;
    end else begin
      state_reg    <= state_next;
      hold_reg     <= 1'b0;
      inflight_reg <= post_cnt[CNT_WIDTH-1:0];
      if (tok_read)
        data_reg <= tok_dout;
      if (ap_done && inflight_reg == '0 && !hs)
        err_reg <= 1'b1;
    end
  end

  assign start_data = data_reg;
  assign inflight   = inflight_reg;
  assign err_sticky = err_reg;

`ifdef START_TOKEN_READER_STATS_EN
  logic [31:0] tokens_reg;
  logic [31:0] stall_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tokens_reg <= '0;
      stall_reg  <= '0;
    end else begin
      if (tok_read && tokens_reg != 32'hFFFF_FFFF)
        tokens_reg <= tokens_reg + 32'd1;
      if (tok_empty_n && !free && stall_reg != 32'hFFFF_FFFF)
        stall_reg <= stall_reg + 32'd1;
    end
  end

  assign stat_tokens = tokens_reg;
  assign stat_stall  = stall_reg;
`endif

endmodule

// File: tb/tb_start_token_reader.sv
// Bench for start_token_reader: directed vector table, reset-mid-issue sequence, and a randomized
// run against a token-queue reference model.
module tb_start_token_reader;

  localparam int MAXI = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tok_empty_n = 1'b0;
  logic [0:0] tok_dout = '0;
  logic       tok_read;
  logic       ap_start;
  logic       ap_ready = 1'b0;
  logic       ap_done = 1'b0;
  logic [0:0] start_data;
  logic [1:0] inflight;
  logic       err_sticky;
`ifdef START_TOKEN_READER_STATS_EN
  logic [31:0] stat_tokens;
  logic [31:0] stat_stall;
`endif

  int n_vec = 0;
  int n_bad = 0;

  start_token_reader #(.DATA_WIDTH(1), .MAX_INFLIGHT(MAXI), .CNT_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .tok_empty_n(tok_empty_n), .tok_dout(tok_dout),
    .tok_read(tok_read), .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .start_data(start_data), .inflight(inflight),
`ifdef START_TOKEN_READER_STATS_EN
    .stat_tokens(stat_tokens), .stat_stall(stat_stall),
`endif
    .err_sticky(err_sticky));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s #%0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic en, dout, rdy, done;
    logic rd, st, sd;
    int   inf;
    logic err;
  } vec_t;

  vec_t tbl[15];

  // reference model state
  int   q[$];
  bit   m_pend, m_data, m_err, m_hold;
  int   m_inf;
  int   m_tok, m_stall;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    tok_empty_n = 1'b0; tok_dout = '0; ap_ready = 1'b0; ap_done = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    m_pend = 0; m_data = 0; m_err = 0; m_hold = 1; m_inf = 0; m_tok = 0; m_stall = 0;
  endtask

  initial begin
    // en dout rdy done | rd st sd inf err
    tbl[0]  = '{0,0,0,0, 0,0,0,0,0};  // reset state, hold cycle
    tbl[1]  = '{1,1,0,0, 1,0,0,0,0};  // single token popped from IDLE
    tbl[2]  = '{0,0,1,0, 0,1,1,0,0};  // ap_start with payload, handshake
    tbl[3]  = '{0,0,0,1, 0,0,1,1,0};  // done retires it
    tbl[4]  = '{0,0,0,1, 0,0,1,0,0};  // spurious done
    tbl[5]  = '{0,0,0,0, 0,0,1,0,1};  // err_sticky set, count stays 0
    tbl[6]  = '{1,0,0,0, 1,0,1,0,1};
    tbl[7]  = '{1,1,1,0, 1,1,0,0,1};  // back-to-back pop on handshake
    tbl[8]  = '{1,0,1,0, 0,1,1,1,1};  // second hs fills counter, no pop
    tbl[9]  = '{1,0,1,0, 0,0,1,2,1};  // full stall, token stays queued
    tbl[10] = '{1,0,1,1, 1,0,1,2,1};  // done frees slot same cycle
    tbl[11] = '{0,0,1,0, 0,1,0,1,1};
    tbl[12] = '{0,0,0,1, 0,0,0,2,1};
    tbl[13] = '{0,0,0,1, 0,0,0,1,1};
    tbl[14] = '{0,0,0,0, 0,0,0,0,1};

    do_reset();
    for (int i = 0; i < 15; i++) begin
      tok_empty_n = tbl[i].en; tok_dout = tbl[i].dout;
      ap_ready = tbl[i].rdy; ap_done = tbl[i].done;
      #1;
      chk("tok_read",   i, 32'(tok_read),   32'(tbl[i].rd));
      chk("ap_start",   i, 32'(ap_start),   32'(tbl[i].st));
      chk("start_data", i, 32'(start_data), 32'(tbl[i].sd));
      chk("inflight",   i, 32'(inflight),   32'(tbl[i].inf));
      chk("err_sticky", i, 32'(err_sticky), 32'(tbl[i].err));
      @(negedge clk);
    end

    // reset while ISSUE with one PE run in flight
    tok_empty_n = 1'b1; tok_dout = 1'b1; ap_ready = 1'b0; ap_done = 1'b0;
    #1 chk("rst_seq_pop1", 0, 32'(tok_read), 32'd1);
    @(negedge clk);
    tok_dout = 1'b0; ap_ready = 1'b1;
    #1 chk("rst_seq_pop2", 0, 32'(tok_read), 32'd1);
    @(negedge clk);
    ap_ready = 1'b0;
    #1;
    chk("rst_seq_start", 0, 32'(ap_start), 32'd1);
    chk("rst_seq_inf",   0, 32'(inflight), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_start", 0, 32'(ap_start),   32'd0);
    chk("rst_async_inf",   0, 32'(inflight),   32'd0);
    chk("rst_async_err",   0, 32'(err_sticky), 32'd0);
    chk("rst_async_read",  0, 32'(tok_read),   32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_hold_read",  0, 32'(tok_read), 32'd0);
    chk("rst_hold_start", 0, 32'(ap_start), 32'd0);
    @(negedge clk);
    #1 chk("rst_after_read", 0, 32'(tok_read), 32'd1);

    // randomized run against the queue model
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit rdy, done, en, dout, hs, dn, free, rd;
      int post;
      if (cyc == 1500) do_reset();
      if ($urandom_range(2) == 0 && q.size() < 8) q.push_back(int'($urandom_range(1)));
      en   = (q.size() != 0);
      dout = en ? q[0][0] : 1'b0;
      rdy  = ($urandom_range(3) != 0);
      done = (m_inf > 0) ? ($urandom_range(2) == 0) : ($urandom_range(60) == 0);
      tok_empty_n = en; tok_dout = dout; ap_ready = rdy; ap_done = done;

      hs   = m_pend && rdy && (m_inf < MAXI || done);
      dn   = done && (m_inf > 0 || hs);
      post = m_inf + int'(hs) - int'(dn);
      free = post < MAXI;
      rd   = en && free && (!m_pend || hs) && !m_hold;
      #1;
      chk("rnd_tok_read",   cyc, 32'(tok_read),   32'(rd));
      chk("rnd_ap_start",   cyc, 32'(ap_start),   32'(m_pend));
      chk("rnd_start_data", cyc, 32'(start_data), 32'(m_data));
      chk("rnd_inflight",   cyc, 32'(inflight),   32'(m_inf));
      chk("rnd_err_sticky", cyc, 32'(err_sticky), 32'(m_err));
`ifdef START_TOKEN_READER_STATS_EN
      chk("rnd_stat_tokens", cyc, stat_tokens, 32'(m_tok));
      chk("rnd_stat_stall",  cyc, stat_stall,  32'(m_stall));
`endif
      @(posedge clk);
      if (rd) begin
        void'(q.pop_front());
        m_data = dout;
        m_pend = 1;
      end else if (hs) begin
        m_pend = 0;
      end
      if (done && m_inf == 0 && !hs) m_err = 1;
      m_tok   += int'(rd);
      m_stall += int'(en && !free);
      m_inf  = post;
      m_hold = 0;
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
